ula_arbiter: RTL and testbench

Shares the single `ula` instance between two requesters (execute stage and address/PC path) with a valid/ready request handshake and a one-cycle response strobe. The block owns the `ula` instance. It latches the granted requester's operands and opcode, then registers the `ula` result. It returns the result only to the granted requester. Arbitration is fixed-priority, or round-robin when configured.

---
 rtl/ula_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ula_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// Two-requester arbiter around a single ula instance; IDLE -> EXEC -> DONE per operation.
// Define ULA_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).

module ula #(
    parameter int ULA_OP = 4,
    parameter int BITS   = 8
) (
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    input  logic [ULA_OP-1:0] op,
    output logic [BITS-1:0]   y
);
    localparam logic [ULA_OP-1:0] OP_ADD = ULA_OP'(0);
    localparam logic [ULA_OP-1:0] OP_AND = ULA_OP'(1);
    localparam logic [ULA_OP-1:0] OP_OR  = ULA_OP'(2);
    localparam logic [ULA_OP-1:0] OP_XOR = ULA_OP'(3);
    localparam logic [ULA_OP-1:0] OP_NOT = ULA_OP'(4);
    localparam logic [ULA_OP-1:0] OP_SUB = ULA_OP'(5);
    localparam logic [ULA_OP-1:0] OP_SHL = ULA_OP'(6);
    localparam logic [ULA_OP-1:0] OP_SHR = ULA_OP'(7);

    // All results wrap modulo 2^BITS; there is no carry or borrow output.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SUB:  y = a - b;
            OP_SHL:  y = {a[BITS-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[BITS-1:1]};
            default: y = '0;
        endcase
    end
endmodule

module ula_arbiter #(
    parameter int ULA_OP = 4,
    parameter int BITS   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req0_valid_in,
    output logic              req0_ready_out,
    input  logic [BITS-1:0]   req0_a_in,
    input  logic [BITS-1:0]   req0_b_in,
    input  logic [ULA_OP-1:0] req0_op_in,
    output logic              req0_resp_valid_out,
    output logic [BITS-1:0]   req0_result_out,
    input  logic              req1_valid_in,
    output logic              req1_ready_out,
    input  logic [BITS-1:0]   req1_a_in,
    input  logic [BITS-1:0]   req1_b_in,
    input  logic [ULA_OP-1:0] req1_op_in,
    output logic              req1_resp_valid_out,
    output logic [BITS-1:0]   req1_result_out,
    output logic              busy_out,
    output logic [1:0]        state_dbg_out
);
    // Handshake: a request transfers on a rising edge where valid and ready are both
    // high; ready is only offered in IDLE, and a requester holds valid and operands
    // until it sees ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q;
    logic                gid_q;
    logic                grant0, grant1, accept;
    logic [BITS-1:0]     a_q, b_q, ula_y;
    logic [ULA_OP-1:0]   op_q;
    logic [BITS-1:0]     res0_q, res1_q;
    logic                resp0_q, resp1_q;

    assign grant0 = req0_valid_in & (~req1_valid_in | (prio_q == 1'b0));
    assign grant1 = req1_valid_in & (~req0_valid_in | (prio_q == 1'b1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req0_ready_out = 1'b0;
        req1_ready_out = 1'b0;
        accept         = 1'b0;
        case (state_q)
            S_IDLE: begin
                req0_ready_out = grant0;
                req1_ready_out = grant1;
                accept         = grant0 | grant1;
                if (accept) state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ULA_ARB_RR_EN
    // The requester that lost this accept gets priority for the next conflict.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~grant1;
        end
    end
`else
    assign prio_q = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            gid_q   <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
        end else begin
            if (accept) begin
                gid_q <= grant1;
                a_q   <= grant1 ? req1_a_in  : req0_a_in;
                b_q   <= grant1 ? req1_b_in  : req0_b_in;
                op_q  <= grant1 ? req1_op_in : req0_op_in;
            end
            // Only the granted requester's result register moves; strobe spans DONE.
            resp0_q <= (state_q == S_EXEC) & ~gid_q;
            resp1_q <= (state_q == S_EXEC) & gid_q;
            if (state_q == S_EXEC) begin
                if (gid_q) res1_q <= ula_y;
                else       res0_q <= ula_y;
            end
        end
    end

    ula #(
        .ULA_OP(ULA_OP),
        .BITS  (BITS)
    ) u_ula (
        .a (a_q),
        .b (b_q),
        .op(op_q),
        .y (ula_y)
    );

    assign req0_resp_valid_out = resp0_q;
    assign req1_resp_valid_out = resp1_q;
    assign req0_result_out     = res0_q;
    assign req1_result_out     = res1_q;
    assign busy_out            = (state_q != S_IDLE);
    assign state_dbg_out       = state_q;
endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: table vectors, directed corner sequences,
// randomized traffic and an a-b sweep, all checked against a cycle-count model.

module tb_ula_arbiter;
    logic       clk;
    logic       rst_in;
    logic       v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic [3:0] op0, op1;
    logic       req0_ready_out, req1_ready_out;
    logic       req0_resp_valid_out, req1_resp_valid_out;
    logic [7:0] req0_result_out, req1_result_out;
    logic       busy_out;
    logic [1:0] state_dbg_out;

    int checks   = 0;
    int failures = 0;

    ula_arbiter #(.ULA_OP(4), .BITS(8)) dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .req0_valid_in      (v0),
        .req0_ready_out     (req0_ready_out),
        .req0_a_in          (a0),
        .req0_b_in          (b0),
        .req0_op_in         (op0),
        .req0_resp_valid_out(req0_resp_valid_out),
        .req0_result_out    (req0_result_out),
        .req1_valid_in      (v1),
        .req1_ready_out     (req1_ready_out),
        .req1_a_in          (a1),
        .req1_b_in          (b1),
        .req1_op_in         (op1),
        .req1_resp_valid_out(req1_resp_valid_out),
        .req1_result_out    (req1_result_out),
        .busy_out           (busy_out),
        .state_dbg_out      (state_dbg_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Tracks the edge at which the last request was taken; busy, strobe and result
    // timing follow purely from edge distances to that point.
    int         now = 0;
    bit         acc_valid = 0;
    int         acc_edge = 0;
    int         acc_id = 0;
    logic [7:0] acc_res = '0;
    logic [7:0] res_exp [2];
    int         prio_m = 0;
    int         last_acc = -1;

    logic       obs_rdy0, obs_rdy1, obs_resp0, obs_resp1;
    logic [7:0] obs_res0, obs_res1;

    function automatic logic [7:0] ula_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        int r;
        if (op == 4'd5) r = int'(a) - int'(b);
        else            r = int'(a) + int'(b);
        return 8'((r + 512) % 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, exp, now);
        end
    endtask

    task automatic model_reset();
        acc_valid  = 0;
        res_exp[0] = '0;
        res_exp[1] = '0;
        prio_m     = 0;
        last_acc   = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_in = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0;
        a1 = '0; b1 = '0; op1 = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy_out, 0);
        chk("reset_resp0", req0_resp_valid_out, 0);
        chk("reset_resp1", req1_resp_valid_out, 0);
        chk("reset_res0", req0_result_out, 0);
        chk("reset_res1", req1_result_out, 0);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    // One clock: compare every output against the model at the falling edge,
    // then advance the model across the rising edge.
    task automatic run_cycle();
        bit busy_e, g0, g1, r0, r1, p0, p1;
        @(negedge clk);
        if (acc_valid && now == acc_edge + 2) res_exp[acc_id] = acc_res;
        busy_e = acc_valid && (now > acc_edge) && (now <= acc_edge + 2);
        g0 = v0 && (!v1 || prio_m == 0);
        g1 = v1 && (!v0 || prio_m == 1);
        r0 = !busy_e && g0;
        r1 = !busy_e && g1;
        p0 = acc_valid && (now == acc_edge + 2) && (acc_id == 0);
        p1 = acc_valid && (now == acc_edge + 2) && (acc_id == 1);
        chk("ready0", req0_ready_out, r0);
        chk("ready1", req1_ready_out, r1);
        chk("resp0", req0_resp_valid_out, p0);
        chk("resp1", req1_resp_valid_out, p1);
        chk("result0", req0_result_out, res_exp[0]);
        chk("result1", req1_result_out, res_exp[1]);
        chk("busy", busy_out, busy_e);
        obs_rdy0  = req0_ready_out;
        obs_rdy1  = req1_ready_out;
        obs_resp0 = req0_resp_valid_out;
        obs_resp1 = req1_resp_valid_out;
        obs_res0  = req0_result_out;
        obs_res1  = req1_result_out;
        @(posedge clk);
        last_acc = -1;
        if (r0) begin
            acc_valid = 1; acc_edge = now; acc_id = 0;
            acc_res = ula_ref(a0, b0, op0); last_acc = 0;
        end else if (r1) begin
            acc_valid = 1; acc_edge = now; acc_id = 1;
            acc_res = ula_ref(a1, b1, op1); last_acc = 1;
        end
`ifdef ULA_ARB_RR_EN
        if (last_acc >= 0) prio_m = 1 - last_acc;
`endif
        now++;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v0;
        logic [7:0] a0, b0;
        logic [3:0] op0;
        logic       v1;
        logic [7:0] a1, b1;
        logic [3:0] op1;
        int         exp_id;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs [6];
    int   exp_order [4];
    int   got_order [4];

    initial begin
        rst_in = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0;
        a1 = '0; b1 = '0; op1 = '0;
        res_exp[0] = '0;
        res_exp[1] = '0;

        vecs[0] = '{1'b1, 8'h05, 8'h03, 4'd5, 1'b0, 8'h00, 8'h00, 4'd0, 0, 8'h02};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 8'h00, 8'h01, 4'd5, 1, 8'hFF};
        vecs[2] = '{1'b1, 8'hFF, 8'h01, 4'd0, 1'b0, 8'h00, 8'h00, 4'd0, 0, 8'h00};
        vecs[3] = '{1'b1, 8'h10, 8'h01, 4'd5, 1'b1, 8'h20, 8'h02, 4'd5, 0, 8'h0F};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 8'h80, 8'h81, 4'd0, 1, 8'h01};
        vecs[5] = '{1'b1, 8'h00, 8'hFF, 4'd5, 1'b0, 8'h00, 8'h00, 4'd0, 0, 8'h01};

`ifdef ULA_ARB_RR_EN
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif

        // Table vectors, each from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            v0 = vecs[i].v0; a0 = vecs[i].a0; b0 = vecs[i].b0; op0 = vecs[i].op0;
            v1 = vecs[i].v1; a1 = vecs[i].a1; b1 = vecs[i].b1; op1 = vecs[i].op1;
            run_cycle();
            chk("vec_grant", {obs_rdy1, obs_rdy0}, (vecs[i].exp_id == 0) ? 2 'b01 : 2'b10);
            v0 = 1'b0; v1 = 1'b0;
            run_cycle();
            run_cycle();
            chk("vec_resp", {obs_resp1, obs_resp0}, (vecs[i].exp_id == 0) ? 2'b01 : 2'b10);
            chk("vec_result", (vecs[i].exp_id == 0) ? obs_res0 : obs_res1, vecs[i].exp_res);
        end

        // req0 then req1 back to back: each result register only moves for its owner.
        do_reset();
        v0 = 1'b1; a0 = 8'h05; b0 = 8'h03; op0 = 4'd5;
        run_cycle();
        chk("seq_ready0", obs_rdy0, 1);
        v0 = 1'b0;
        run_cycle();
        run_cycle();
        chk("seq_res0", obs_res0, 8'h02);
        chk("seq_res1_idle", obs_res1, 8'h00);
        v1 = 1'b1; a1 = 8'h00; b1 = 8'h01; op1 = 4'd5;
        run_cycle();
        v1 = 1'b0;
        run_cycle();
        run_cycle();
        chk("seq_res1_wrap", obs_res1, 8'hFF);
        chk("seq_res0_hold", obs_res0, 8'h02);

        // Both requesters continuously valid for four operations.
        do_reset();
        v0 = 1'b1; a0 = 8'h40; b0 = 8'h01; op0 = 4'd5;
        v1 = 1'b1; a1 = 8'h70; b1 = 8'h02; op1 = 4'd0;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 30 && n < 4; c++) begin
                run_cycle();
                if (obs_rdy0)      begin got_order[n] = 0; n++; end
                else if (obs_rdy1) begin got_order[n] = 1; n++; end
                if (last_acc == 0) begin a0 = a0 + 8'h11; b0 = b0 + 8'h01; end
                if (last_acc == 1) begin a1 = a1 + 8'h13; b1 = b1 + 8'h03; end
            end
            chk("grant_count", n, 4);
            for (int i = 0; i < 4; i++) chk("grant_order", got_order[i], exp_order[i]);
        end
        v0 = 1'b0; v1 = 1'b0;
        run_cycle();
        run_cycle();
        run_cycle();

        // Reset during EXEC drops the in-flight response; the held request re-enters.
        do_reset();
        v0 = 1'b1; a0 = 8'h33; b0 = 8'h11; op0 = 4'd5;
        run_cycle();
        @(negedge clk);
        chk("rst_exec_busy", busy_out, 1);
        rst_in = 1'b1;
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_resp0", req0_resp_valid_out, 0);
        chk("rst_res0", req0_result_out, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp0_late", req0_resp_valid_out, 0);
        chk("rst_res0_late", req0_result_out, 0);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        model_reset();
        run_cycle();
        chk("rst_reaccept", obs_rdy0, 1);
        v0 = 1'b0;
        run_cycle();
        run_cycle();
        chk("rst_reaccept_res0", obs_res0, 8'h22);

        // Randomized traffic; requesters hold until accepted.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            run_cycle();
            if (last_acc == 0 || !v0) begin
                v0  = 1'($urandom_range(0, 1));
                a0  = 8'($urandom);
                b0  = 8'($urandom);
                op0 = ($urandom_range(0, 1) == 1) ? 4'd5 : 4'd0;
            end
            if (last_acc == 1 || !v1) begin
                v1  = 1'($urandom_range(0, 1));
                a1  = 8'($urandom);
                b1  = 8'($urandom);
                op1 = ($urandom_range(0, 1) == 1) ? 4'd5 : 4'd0;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        run_cycle();
        run_cycle();
        run_cycle();

        // Subtraction sweep on req0.
        do_reset();
        for (int ai = 0; ai < 256; ai += 17) begin
            for (int bi = 0; bi < 256; bi++) begin
                v0 = 1'b1; a0 = 8'(ai); b0 = 8'(bi); op0 = 4'd5;
                run_cycle();
                v0 = 1'b0;
                run_cycle();
                run_cycle();
                chk("sweep_sub", obs_res0, (ai - bi + 256) % 256);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
